// File: rtl/move_cmd_gen.sv
// move_cmd_gen: turns three push-buttons and a gravity timer into one-cycle
// drop/left/right move commands, arbitrated drop > left > right.
module move_cmd_gen #(
  parameter int unsigned GRAVITY_TICKS   = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  output logic drop,
  output logic left,
  output logic right
);

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned BTN_DOWN  = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_RIGHT = 2;
  localparam int unsigned GW = (GRAVITY_TICKS > 2) ? $clog2(GRAVITY_TICKS) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // Counter value from which the next enabled increment reaches GRAVITY_TICKS-1
  localparam logic [GW-1:0] GRAV_LAST = GW'(GRAVITY_TICKS - 2);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] w_btn_raw;
  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [NUM_BTN-1:0] w_rise;

  logic [GW-1:0] r_grav;
  logic          w_grav_wrap;
  logic          w_expire;

  logic r_pend_drop;
  logic r_pend_left;
  logic r_pend_right;
  logic w_win_drop;
  logic w_win_left;
  logic w_win_right;

  logic r_drop;
  logic r_left;
  logic r_right;

  assign w_btn_raw = {btn_right, btn_left, btn_down};

  // Two-flop synchronizer for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    logic [DW-1:0] r_cnt;
    logic          r_deb;
    logic          w_done;

    assign w_done   = (r_sync2[g] != r_deb) && (r_cnt == DEB_LAST);
    assign w_rise[g] = w_done & r_sync2[g];

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else if (r_sync2[g] == r_deb) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_cnt <= '0;
        r_deb <= r_sync2[g];
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

  // Fixed-priority pick among pending commands
  always_comb begin
    w_win_drop  = 1'b0;
    w_win_left  = 1'b0;
    w_win_right = 1'b0;
    if (r_pend_drop) begin
      w_win_drop = 1'b1;
    end else if (r_pend_left) begin
      w_win_left = 1'b1;
    end else if (r_pend_right) begin
      w_win_right = 1'b1;
    end
  end

  // An issued drop restarts gravity, so it also suppresses a coincident expiry
  assign w_grav_wrap = (r_grav == GRAV_LAST);
  assign w_expire    = w_grav_wrap & ~w_win_drop;

  // Gravity timer: counts enabled cycles, holds while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grav <= '0;
    end else if (enable) begin
      if (w_win_drop || w_grav_wrap) begin
        r_grav <= '0;
      end else begin
        r_grav <= r_grav + GW'(1);
      end
    end
  end

  // Pending flags: set by events, cleared when issued, flushed while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_drop  <= 1'b0;
      r_pend_left  <= 1'b0;
      r_pend_right <= 1'b0;
    end else if (!enable) begin
      r_pend_drop  <= 1'b0;
      r_pend_left  <= 1'b0;
      r_pend_right <= 1'b0;
    end else begin
      r_pend_drop  <= w_expire | w_rise[BTN_DOWN] | (r_pend_drop & ~w_win_drop);
      r_pend_left  <= w_rise[BTN_LEFT] | (r_pend_left & ~w_win_left);
      r_pend_right <= w_rise[BTN_RIGHT] | (r_pend_right & ~w_win_right);
    end
  end

  // Registered one-cycle command pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop  <= 1'b0;
      r_left  <= 1'b0;
      r_right <= 1'b0;
    end else begin
      r_drop  <= enable & w_win_drop;
      r_left  <= enable & w_win_left;
      r_right <= enable & w_win_right;
    end
  end

  assign drop  = r_drop;
  assign left  = r_left;
  assign right = r_right;

endmodule

// File: doc/move_cmd_gen.md
MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 Parameter GRAVITY_TICKS, default 25000000, clk cycles between automatic drop commands; legal range 2 to 2^26-1.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000, consecutive stable cycles required before a button change is accepted; legal range 2 to 2^20-1.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 enable  input  1  game running; low freezes command generation.
REQ-006 btn_left, btn_right, btn_down  input  1 each  raw asynchronous push-buttons, active-high.
REQ-007 drop  output  1  registered one-cycle move-down command.
REQ-008 left  output  1  registered one-cycle move-left command.
REQ-009 right  output  1  registered one-cycle move-right command.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each synchronized button SHALL have its own debounce counter; the debounced level flips only after the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-012 A debounced 0->1 transition SHALL set that button's pending flag; 1->0 transitions generate nothing; holding gives no auto-repeat.
REQ-013 The gravity counter SHALL increment every enabled cycle and, on reaching GRAVITY_TICKS-1, set the drop pending flag and wrap to 0.
REQ-014 Drop pending SHALL be set by either gravity expiry or a btn_down press; both in the same cycle yield a single drop.
REQ-015 At most one of drop/left/right SHALL be high in any cycle.
REQ-016 Arbitration each cycle: drop pending > left pending > right pending; the winner is driven high for exactly the next cycle and its pending flag cleared; losers stay pending.
REQ-017 A pending flag set again while already pending SHALL not queue a second command.
REQ-018 Issuing any drop SHALL clear the gravity counter to 0.
REQ-019 No-conflict latency: press to command pulse = DEBOUNCE_CYCLES+3 edges, counting the first edge that samples the raw button high as edge 1; the pulse is high in the cycle following that edge.
REQ-020 enable low SHALL hold the gravity counter, clear all pending flags, force outputs to 0; debouncers keep running, and a press completing debounce while disabled is discarded.
REQ-021 enable low->high SHALL resume gravity counting from its held value.

Reset
REQ-022 rst_n low SHALL immediately force drop, left, right to 0 and clear synchronizers, debounced levels, debounce counters, gravity counter and pending flags, regardless of clk.
REQ-023 A button already held at rst_n release SHALL be reported as a press after normal debounce latency.
REQ-024 Reset asserted mid-arbitration SHALL discard all pending commands; none issue after release.

Verification (GRAVITY_TICKS=8, DEBOUNCE_CYCLES=4)
REQ-025 Buttons idle, enable=1 after reset -> drop pulses once per 8 cycles, one cycle wide, left=right=0 throughout.
REQ-026 btn_left held high from edge 1 -> left high exactly in the cycle after edge 7, once only while held.
REQ-027 btn_left glitch high for 3 cycles then low -> no left pulse ever.
REQ-028 Debounced btn_left and btn_right accepted with gravity expiring the same cycle -> drop, then left, then right in three consecutive cycles; gravity restarts at 0 after the drop.
REQ-029 btn_down accepted 2 cycles before gravity expiry -> one drop, next automatic drop 8 cycles later.
REQ-030 enable dropped with left pending, rst_n pulsed low mid-pulse -> outputs 0 immediately, no left issued after re-enable or reset release.
